// File: rtl/alu_flow_if.sv
// Operand/result handshake bundle for alu_flow: valid/ready input channel,
// valid/ready result channel with flags, and the multiply busy indicator.
interface alu_flow_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op_code;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y_out;
    logic             cout;
    logic             zero;
    logic             neg;
    logic             ovf;
    logic             op_err;
    logic             busy;

    modport master (
        output in_valid, op_code, a_in, b_in, out_ready,
        input  in_ready, out_valid, y_out, cout, zero, neg, ovf, op_err, busy
    );

    modport slave (
        input  in_valid, op_code, a_in, b_in, out_ready,
        output in_ready, out_valid, y_out, cout, zero, neg, ovf, op_err, busy
    );
endinterface

// File: rtl/alu_flow.sv
// Handshaked WIDTH-bit ALU with a stored carry flag consumed by ADC/SBC.
// Define ALU_FLOW_MUL_EN to add the iterative shift-add multiply on op 1110.
module alu_flow #(
    parameter int   WIDTH      = 16,
    parameter logic CARRY_INIT = 1'b0
) (
    input  logic      clk,
    input  logic      reset_n,
    alu_flow_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OUT  = 2'd2;
`ifdef ALU_FLOW_MUL_EN
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [3:0] OP_MUL  = 4'b1110;
    localparam int         CW      = $clog2(WIDTH);
`endif

    localparam logic [3:0] OP_PASS = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_ADC  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_SBC  = 4'b0100;
    localparam logic [3:0] OP_INC  = 4'b0101;
    localparam logic [3:0] OP_DEC  = 4'b0110;
    localparam logic [3:0] OP_CMP  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_AND  = 4'b1010;
    localparam logic [3:0] OP_NOT  = 4'b1011;
    localparam logic [3:0] OP_SHL  = 4'b1100;
    localparam logic [3:0] OP_SHR  = 4'b1101;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic             accept;
    logic             is_mul;
    logic             a_msb, b_msb;
    logic [WIDTH:0]   ext;
    logic [WIDTH:0]   cin_ext;
    logic [WIDTH:0]   one_ext;
    logic [WIDTH-1:0] alu_y;
    logic [WIDTH-1:0] res_y;
    logic             alu_c, alu_v, alu_err;

    assign bus.in_ready = (state_q == ST_IDLE) | ((state_q == ST_OUT) & bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;
    assign a_msb        = bus.a_in[WIDTH-1];
    assign b_msb        = bus.b_in[WIDTH-1];
    assign cin_ext      = {{WIDTH{1'b0}}, c_q};
    assign one_ext      = {{WIDTH{1'b0}}, 1'b1};

    // alu_y is the flag basis; CMP reports flags of a-b but passes a through.
    always_comb begin
        ext     = '0;
        alu_y   = '0;
        alu_c   = c_q;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (bus.op_code)
            OP_PASS: alu_y = bus.a_in;
            OP_ADD, OP_ADC: begin
                ext   = {1'b0, bus.a_in} + {1'b0, bus.b_in}
                      + ((bus.op_code == OP_ADC) ? cin_ext : '0);
                alu_y = ext[WIDTH-1:0];
                alu_c = ext[WIDTH];
                alu_v = (a_msb == b_msb) & (alu_y[WIDTH-1] != a_msb);
            end
            OP_SUB, OP_SBC, OP_CMP: begin
                ext   = {1'b0, bus.a_in} - {1'b0, bus.b_in}
                      - ((bus.op_code == OP_SBC) ? cin_ext : '0);
                alu_y = ext[WIDTH-1:0];
                alu_c = ext[WIDTH];
                alu_v = (a_msb != b_msb) & (alu_y[WIDTH-1] != a_msb);
            end
            OP_INC: begin
                ext   = {1'b0, bus.a_in} + one_ext;
                alu_y = ext[WIDTH-1:0];
                alu_c = ext[WIDTH];
                alu_v = ~a_msb & alu_y[WIDTH-1];
            end
            OP_DEC: begin
                ext   = {1'b0, bus.a_in} - one_ext;
                alu_y = ext[WIDTH-1:0];
                alu_c = ext[WIDTH];
                alu_v = a_msb & ~alu_y[WIDTH-1];
            end
            OP_OR:  begin alu_y = bus.a_in | bus.b_in; alu_c = 1'b0; end
            OP_XOR: begin alu_y = bus.a_in ^ bus.b_in; alu_c = 1'b0; end
            OP_AND: begin alu_y = bus.a_in & bus.b_in; alu_c = 1'b0; end
            OP_NOT: begin alu_y = ~bus.a_in;           alu_c = 1'b0; end
            OP_SHL: begin alu_y = {bus.a_in[WIDTH-2:0], 1'b0}; alu_c = a_msb; end
            OP_SHR: begin alu_y = {1'b0, bus.a_in[WIDTH-1:1]}; alu_c = bus.a_in[0]; end
            default: begin
                alu_y   = '0;
                alu_c   = 1'b0;
                alu_err = 1'b1;
            end
        endcase
    end

    assign res_y = (bus.op_code == OP_CMP) ? bus.a_in : alu_y;

`ifdef ALU_FLOW_MUL_EN
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               mul_done;
    logic [WIDTH-1:0]   mul_y;
    logic               mul_c;

    assign is_mul   = (bus.op_code == OP_MUL);
    assign mul_done = (state_q == ST_MUL) && (cnt_q == CW'(WIDTH - 1));
    assign mul_y    = prod_d[WIDTH-1:0];
    assign mul_c    = |prod_d[2*WIDTH-1:WIDTH];
    assign bus.busy = (state_q == ST_MUL);

    // One partial product per cycle; the last step feeds the result registers directly.
    always_comb begin
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (accept) begin
            mcand_d  = {{WIDTH{1'b0}}, bus.a_in};
            mplier_d = bus.b_in;
            prod_d   = '0;
            cnt_d    = '0;
        end else if (state_q == ST_MUL) begin
            prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    assign is_mul   = 1'b0;
    assign bus.busy = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        c_d     = c_q;
        cout_d  = cout_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
`ifdef ALU_FLOW_MUL_EN
            ST_MUL: begin
                if (mul_done) begin
                    y_d     = mul_y;
                    c_d     = mul_c;
                    cout_d  = mul_c;
                    zero_d  = (mul_y == '0);
                    neg_d   = mul_y[WIDTH-1];
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_OUT;
                end
            end
`endif
            default: begin
                if (accept && is_mul) begin
`ifdef ALU_FLOW_MUL_EN
                    state_d = ST_MUL;
`endif
                end else if (accept) begin
                    y_d     = res_y;
                    c_d     = alu_c;
                    cout_d  = alu_c;
                    zero_d  = (alu_y == '0);
                    neg_d   = alu_y[WIDTH-1];
                    ovf_d   = alu_v;
                    err_d   = alu_err;
                    state_d = ST_OUT;
                end else if ((state_q == ST_OUT) && bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            c_q     <= CARRY_INIT;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign bus.out_valid = (state_q == ST_OUT);
    assign bus.y_out     = y_q;
    assign bus.cout      = cout_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.ovf       = ovf_q;
    assign bus.op_err    = err_q;
endmodule

// File: tb/tb_alu_flow.sv
// Self-checking bench for alu_flow: directed scenarios plus a randomized
// handshake run scored against an arithmetic reference model.
module tb_alu_flow;
    localparam int   W     = 16;
    localparam logic CINIT = 1'b0;

    // {out_valid, y, c, zero, neg, ovf, op_err}
    typedef logic [21:0] res_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic model_c;
    res_t exp_q[$];

    alu_flow_if #(.WIDTH(W)) bus ();

    alu_flow #(.WIDTH(W), .CARRY_INIT(CINIT)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic res_t observe();
        return {bus.out_valid, bus.y_out, bus.cout, bus.zero, bus.neg, bus.ovf, bus.op_err};
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic res_t model(input int op, input int a, input int b, input logic cin);
        int          r, sa, sb, sr;
        longint      p;
        logic        c, v, e, arith;
        logic [15:0] f, y;
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        r = 0; sr = 0; p = 0; c = 1'b0; e = 1'b0;
        arith = (op >= 1 && op <= 7);
        case (op)
            0:    begin r = a; c = cin; end
            1:    begin r = a + b; c = (r > 65535); sr = sa + sb; end
            2:    begin r = a + b + int'(cin); c = (r > 65535); sr = sa + sb + int'(cin); end
            3, 7: begin r = a - b; c = (a < b); sr = sa - sb; end
            4:    begin r = a - b - int'(cin); c = (a < b + int'(cin)); sr = sa - sb - int'(cin); end
            5:    begin r = a + 1; c = (a == 65535); sr = sa + 1; end
            6:    begin r = a - 1; c = (a == 0); sr = sa - 1; end
            8:    r = a | b;
            9:    r = a ^ b;
            10:   r = a & b;
            11:   r = 65535 - a;
            12:   begin r = a * 2; c = (a >= 32768); end
            13:   begin r = a / 2; c = (a % 2 == 1); end
`ifdef ALU_FLOW_MUL_EN
            14:   begin p = longint'(a) * longint'(b); r = int'(p % 65536); c = (p >= 65536); end
`endif
            default: e = 1'b1;
        endcase
        v = arith && (sr > 32767 || sr < -32768);
        f = r[15:0];
        y = (op == 7) ? a[15:0] : f;
        return {1'b1, y, c, (f == 16'h0000), f[15], v, e};
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            4:       return 16'h0001;
            default: return 16'($urandom());
        endcase
    endfunction

    task automatic apply_reset();
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op_code   = 4'h0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_c = CINIT;
        exp_q.delete();
        @(negedge clk);
    endtask

    // Presents an op, waits (bounded) for acceptance, returns at the following negedge.
    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output res_t e, output int waits);
        bus.in_valid = 1'b1;
        bus.op_code  = op;
        bus.a_in     = a;
        bus.b_in     = b;
        waits = 0;
        #1;
        while (!bus.in_ready && waits < 40) begin
            @(negedge clk); #1;
            waits++;
        end
        n_cmp++;
        if (!bus.in_ready) begin
            n_bad++;
            $display("[TB] FAIL accept_timeout op=%h: in_ready=%b required 1", op, bus.in_ready);
        end
        e = model(int'(op), int'(a), int'(b), model_c);
        model_c = e[4];
        @(negedge clk);
    endtask

    task automatic test_reset();
        res_t got;
        apply_reset();
        #1;
        got = observe();
        n_cmp++;
        if (got !== 22'h0) begin
            n_bad++; $display("[TB] FAIL reset_outputs: got %h required %h", got, 22'h0);
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++; $display("[TB] FAIL reset_busy: got %b required 0", bus.busy);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("[TB] FAIL reset_in_ready: got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        res_t e, got, req;
        int   w;
        bus.out_ready = 1'b1;
        send(4'h1, 16'hFFFF, 16'h0001, e, w);
        got = observe(); req = {1'b1, 16'h0000, 5'b11000};
        n_cmp++;
        if (got !== req) begin n_bad++; $display("[TB] FAIL add_wrap: got %h required %h", got, req); end
        send(4'h2, 16'h0001, 16'h0002, e, w);
        n_cmp++;
        if (w !== 0) begin n_bad++; $display("[TB] FAIL adc_same_cycle: waited %0d required 0", w); end
        got = observe(); req = {1'b1, 16'h0004, 5'b00000};
        n_cmp++;
        if (got !== req) begin n_bad++; $display("[TB] FAIL adc_carry_in: got %h required %h", got, req); end
        send(4'h3, 16'h7FFF, 16'hFFFF, e, w);
        got = observe(); req = {1'b1, 16'h8000, 5'b10110};
        n_cmp++;
        if (got !== req) begin n_bad++; $display("[TB] FAIL sub_ovf: got %h required %h", got, req); end
        send(4'h4, 16'h0005, 16'h0002, e, w);
        got = observe(); req = {1'b1, 16'h0002, 5'b00000};
        n_cmp++;
        if (got !== req) begin n_bad++; $display("[TB] FAIL sbc_borrow_in: got %h required %h", got, req); end
        bus.in_valid = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++; $display("[TB] FAIL drained_valid: got %b required 0", bus.out_valid);
        end
    endtask

    task automatic test_stall();
        res_t e, got, held, req;
        int   w;
        bus.out_ready = 1'b0;
        send(4'hA, 16'hF0F0, 16'h3C3C, e, w);
        held = observe(); req = {1'b1, 16'h3030, 5'b00000};
        n_cmp++;
        if (held !== req) begin n_bad++; $display("[TB] FAIL and_result: got %h required %h", held, req); end
        bus.op_code = 4'h9; bus.a_in = 16'h00FF; bus.b_in = 16'h0F0F;
        for (int i = 0; i < 3; i++) begin
            #1;
            got = observe();
            n_cmp++;
            if (got !== req) begin n_bad++; $display("[TB] FAIL stall_hold_%0d: got %h required %h", i, got, req); end
            n_cmp++;
            if (bus.in_ready !== 1'b0) begin
                n_bad++; $display("[TB] FAIL stall_in_ready_%0d: got %b required 0", i, bus.in_ready);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("[TB] FAIL release_in_ready: got %b required 1", bus.in_ready);
        end
        @(negedge clk); #1;
        got = observe(); req = {1'b1, 16'h0FF0, 5'b00000};
        n_cmp++;
        if (got !== req) begin n_bad++; $display("[TB] FAIL xor_after_stall: got %h required %h", got, req); end
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_illegal();
        res_t e, got, req;
        int   w;
        bus.out_ready = 1'b1;
        send(4'hF, 16'h1234, 16'h5678, e, w);
        got = observe(); req = {1'b1, 16'h0000, 5'b01001};
        n_cmp++;
        if (got !== req) begin n_bad++; $display("[TB] FAIL illegal_op: got %h required %h", got, req); end
        send(4'h8, 16'h8001, 16'h0002, e, w);
        got = observe(); req = {1'b1, 16'h8003, 5'b00100};
        n_cmp++;
        if (got !== req) begin n_bad++; $display("[TB] FAIL err_clears: got %h required %h", got, req); end
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul();
        res_t e, got, req;
        int   w;
        bus.out_ready = 1'b1;
`ifdef ALU_FLOW_MUL_EN
        for (int k = 0; k < 2; k++) begin
            int cycles, busy_cnt;
            if (k == 0) begin
                send(4'hE, 16'h0012, 16'h0034, e, w); req = {1'b1, 16'h03A8, 5'b00000};
            end else begin
                send(4'hE, 16'h0100, 16'h0100, e, w); req = {1'b1, 16'h0000, 5'b11000};
            end
            bus.in_valid = 1'b0;
            cycles = 1; busy_cnt = 0;
            #1;
            while (!bus.out_valid && cycles < 40) begin
                if (bus.busy) busy_cnt++;
                @(negedge clk); #1;
                cycles++;
            end
            n_cmp++;
            if (cycles !== 17) begin n_bad++; $display("[TB] FAIL mul%0d_latency: got %0d required 17", k, cycles); end
            n_cmp++;
            if (busy_cnt !== 16) begin n_bad++; $display("[TB] FAIL mul%0d_busy: got %0d required 16", k, busy_cnt); end
            got = observe();
            n_cmp++;
            if (got !== req) begin n_bad++; $display("[TB] FAIL mul%0d_result: got %h required %h", k, got, req); end
            @(negedge clk);
        end
`else
        send(4'hE, 16'h0012, 16'h0034, e, w);
        got = observe(); req = {1'b1, 16'h0000, 5'b01001};
        n_cmp++;
        if (got !== req) begin n_bad++; $display("[TB] FAIL mul_disabled: got %h required %h", got, req); end
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL mul_disabled_busy: got %b required 0", bus.busy); end
        bus.in_valid = 1'b0;
        @(negedge clk);
`endif
    endtask

    task automatic test_reset_mid_op();
        res_t e, got, req;
        int   w, stray;
        bus.out_ready = 1'b1;
        send(4'hC, 16'h8000, 16'h0000, e, w);
        got = observe(); req = {1'b1, 16'h0000, 5'b11000};
        n_cmp++;
        if (got !== req) begin n_bad++; $display("[TB] FAIL shl_carry: got %h required %h", got, req); end
`ifdef ALU_FLOW_MUL_EN
        send(4'hE, 16'h0003, 16'h0005, e, w);
        bus.in_valid = 1'b0;
        repeat (7) @(negedge clk);
`else
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
`endif
        reset_n = 1'b0;
        #1;
        got = observe();
        n_cmp++;
        if (got !== 22'h0) begin n_bad++; $display("[TB] FAIL mid_reset_outputs: got %h required 0", got); end
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_reset_busy: got %b required 0", bus.busy); end
        @(negedge clk);
        reset_n = 1'b1;
        model_c = CINIT;
        bus.out_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL post_reset_ready: got %b required 1", bus.in_ready); end
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) stray++;
            @(negedge clk); #1;
        end
        n_cmp++;
        if (stray !== 0) begin n_bad++; $display("[TB] FAIL stray_valid: got %0d cycles required 0", stray); end
        send(4'h2, 16'h0000, 16'h0000, e, w);
        got = observe(); req = {1'b1, 16'(CINIT), 1'b0, ~CINIT, 3'b000};
        n_cmp++;
        if (got !== req) begin n_bad++; $display("[TB] FAIL carry_init: got %h required %h", got, req); end
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        res_t e, got;
        int   left;
        apply_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.op_code   = 4'($urandom_range(0, 15));
            bus.a_in      = pick();
            bus.b_in      = pick();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("[TB] FAIL rand_spurious at %0d: out_valid=1 required 0", cyc);
                end else begin
                    e = exp_q.pop_front();
                    got = observe();
                    if (got !== e) begin
                        n_bad++; $display("[TB] FAIL rand_result at %0d: got %h required %h", cyc, got, e);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e = model(int'(bus.op_code), int'(bus.a_in), int'(bus.b_in), model_c);
                model_c = e[4];
                exp_q.push_back(e);
            end
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        left = 40;
        while (exp_q.size() != 0 && left > 0) begin
            #1;
            if (bus.out_valid) begin
                e = exp_q.pop_front();
                got = observe();
                n_cmp++;
                if (got !== e) begin n_bad++; $display("[TB] FAIL rand_drain: got %h required %h", got, e); end
            end
            @(negedge clk);
            left--;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("[TB] FAIL rand_drain_timeout: %0d results outstanding required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_mul();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
